msx_ram_mapper_gen: RTL and testbench

//  Parametrised MSX memory mapper: four page segment registers (I/O FC-FF) for up
//  to 2^SEG_BITS 16 KB segments, with selectable read-back mode, write-edge

---
 rtl/msx_ram_mapper_gen.sv | 158 +++++++++++++++
 tb/tb_msx_ram_mapper_gen.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_ram_mapper_gen.sv
// msx_ram_mapper_gen
//   Parametrised MSX memory mapper. Four page segment registers are written
//   through I/O ports IO_BASE..IO_BASE+3. For SEG_BITS > 8 an extension port
//   (EXT_PORT) supplies the upper segment bits. A clear engine fills all
//   installed RAM with CLEAR_VALUE through a req/ack write interface.
// Ports
//   clk, reset                    clock, async active-high reset
//   cpu_iorq/m1/wr/rd             Z80 bus control (active high)
//   cpu_addr, cpu_dout            CPU address and write data
//   en                            read-back enable
//   ram_block_count               installed 16 KB blocks (power of two or 0)
//   mapper_dout                   read-back data (FF when not selected)
//   mapper_addr                   physical RAM address for cpu_addr
//   clr_start                     start clearing installed RAM
//   clr_busy, clr_done            engine active / one-cycle completion pulse
//   clr_req, clr_ack              write handshake to the RAM arbiter
//   clr_addr, clr_data            clear write address and data
module msx_ram_mapper_gen #(
   parameter int         SEG_BITS    = 8,
   parameter logic [7:0] IO_BASE     = 8'hFC,
   parameter logic [7:0] EXT_PORT    = 8'hF7,
   parameter int         RB_MODE     = 0,
   parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_iorq,
   input  logic                   cpu_m1,
   input  logic                   cpu_wr,
   input  logic                   cpu_rd,
   input  logic [15:0]            cpu_addr,
   input  logic [7:0]             cpu_dout,
   input  logic                   en,
   input  logic [SEG_BITS:0]      ram_block_count,
   output logic [7:0]             mapper_dout,
   output logic [SEG_BITS+13:0]   mapper_addr,
   input  logic                   clr_start,
   output logic                   clr_busy,
   output logic                   clr_done,
   output logic                   clr_req,
   input  logic                   clr_ack,
   output logic [SEG_BITS+13:0]   clr_addr,
   output logic [7:0]             clr_data
);

   localparam int AW = SEG_BITS + 14;

   typedef enum logic [1:0] {CLR_IDLE, CLR_REQ, CLR_DONE} clr_state_t;

   logic [SEG_BITS-1:0] seg [4];
   logic [SEG_BITS-1:0] mask;
   logic [SEG_BITS-1:0] wval;
   logic [SEG_BITS-1:0] rd_seg;
   logic                cnt_nz;
   logic                mpr_rq;
   logic                ext_rq;
   logic                wr_strobe;
   logic                wr_prev;
   logic                commit;
   clr_state_t          clr_state;
   logic [AW-1:0]       clr_last;

   assign cnt_nz    = |ram_block_count;
   assign mask      = cnt_nz ? SEG_BITS'(ram_block_count - 1'b1) : '0;
   assign mpr_rq    = cpu_iorq & ~cpu_m1 & (cpu_addr[7:2] == IO_BASE[7:2]);
   assign wr_strobe = (mpr_rq | ext_rq) & cpu_wr;
   // wr_prev resets high so a strobe already active at reset release never commits
   assign commit    = wr_strobe & ~wr_prev;

   generate
      if (SEG_BITS > 8) begin : g_ext
         logic [SEG_BITS-9:0] ext_hi;
         assign ext_rq = cpu_iorq & ~cpu_m1 & (cpu_addr[7:0] == EXT_PORT);
         assign wval   = {ext_hi, cpu_dout};
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               ext_hi <= '0;
            else if (commit & ext_rq)
               ext_hi <= cpu_dout[SEG_BITS-9:0];
         end
      end else begin : g_noext
         assign ext_rq = 1'b0;
         assign wval   = cpu_dout;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 4; i++)
            seg[i] <= '0;
         wr_prev <= 1'b1;
      end else begin
         wr_prev <= wr_strobe;
         if (commit & mpr_rq)
            seg[cpu_addr[1:0]] <= wval;
      end
   end

   assign mapper_addr = {seg[cpu_addr[15:14]] & mask, cpu_addr[13:0]};
   assign rd_seg      = seg[cpu_addr[1:0]];

   always_comb begin
      mapper_dout = 8'hFF;
      if (mpr_rq & cpu_rd & en & cnt_nz) begin
         case (RB_MODE)
            0:       mapper_dout = rd_seg[7:0] | ~mask[7:0];
            1:       mapper_dout = rd_seg[7:0];
            default: mapper_dout = 8'hFF;
         endcase
      end
   end

   assign clr_data = CLEAR_VALUE;

   // Last address = count*16K-1; for a power-of-two count this is {mask, 14'h3FFF}
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_state <= CLR_IDLE;
         clr_busy  <= 1'b0;
         clr_req   <= 1'b0;
         clr_done  <= 1'b0;
         clr_addr  <= '0;
         clr_last  <= '0;
      end else begin
         clr_done <= 1'b0;
         case (clr_state)
            CLR_IDLE: begin
               if (clr_start) begin
                  if (cnt_nz) begin
                     clr_last  <= {mask, 14'h3FFF};
                     clr_addr  <= '0;
                     clr_busy  <= 1'b1;
                     clr_req   <= 1'b1;
                     clr_state <= CLR_REQ;
                  end else begin
                     clr_done <= 1'b1;
                  end
               end
            end
            CLR_REQ: begin
               if (clr_ack) begin
                  if (clr_addr == clr_last) begin
                     clr_req   <= 1'b0;
                     clr_busy  <= 1'b0;
                     clr_done  <= 1'b1;
                     clr_state <= CLR_DONE;
                  end else begin
                     clr_addr <= clr_addr + AW'(1);
                  end
               end
            end
            CLR_DONE: clr_state <= CLR_IDLE;
            default:  clr_state <= CLR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msx_ram_mapper_gen.sv
// tb_msx_ram_mapper_gen
//   Directed bench for msx_ram_mapper_gen. Four instances share the CPU bus:
//   dut0 (defaults, also drives the clear engine), dut10 (SEG_BITS=10),
//   dut_rb1 (RB_MODE=1) and dut_rb2 (RB_MODE=2).
module tb_msx_ram_mapper_gen;

   logic        clk;
   logic        reset;
   logic        cpu_iorq, cpu_m1, cpu_wr, cpu_rd;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        en;
   logic [8:0]  count;
   logic [10:0] count10;
   logic        clr_start, clr_ack;

   logic [7:0]  dout0, dout10, dout_rb1, dout_rb2;
   logic [21:0] maddr0, maddr_rb1, maddr_rb2;
   logic [23:0] maddr10;
   logic        clr_busy0, clr_done0, clr_req0;
   logic [21:0] clr_addr0;
   logic [7:0]  clr_data0;
   logic        busy10, done10, req10;
   logic [23:0] caddr10;
   logic [7:0]  cdata10;
   logic        busy1, done1, req1, busy2, done2, req2;
   logic [21:0] caddr1, caddr2;
   logic [7:0]  cdata1, cdata2;

   int unsigned pass_cnt = 0;
   int unsigned tot_cnt  = 0;

   msx_ram_mapper_gen dut0 (
      .clk(clk), .reset(reset), .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1), .cpu_wr(cpu_wr),
      .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .en(en),
      .ram_block_count(count), .mapper_dout(dout0), .mapper_addr(maddr0),
      .clr_start(clr_start), .clr_busy(clr_busy0), .clr_done(clr_done0), .clr_req(clr_req0),
      .clr_ack(clr_ack), .clr_addr(clr_addr0), .clr_data(clr_data0));

   msx_ram_mapper_gen #(.SEG_BITS(10)) dut10 (
      .clk(clk), .reset(reset), .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1), .cpu_wr(cpu_wr),
      .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .en(en),
      .ram_block_count(count10), .mapper_dout(dout10), .mapper_addr(maddr10),
      .clr_start(1'b0), .clr_busy(busy10), .clr_done(done10), .clr_req(req10),
      .clr_ack(1'b0), .clr_addr(caddr10), .clr_data(cdata10));

   msx_ram_mapper_gen #(.RB_MODE(1)) dut_rb1 (
      .clk(clk), .reset(reset), .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1), .cpu_wr(cpu_wr),
      .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .en(en),
      .ram_block_count(count), .mapper_dout(dout_rb1), .mapper_addr(maddr_rb1),
      .clr_start(1'b0), .clr_busy(busy1), .clr_done(done1), .clr_req(req1),
      .clr_ack(1'b0), .clr_addr(caddr1), .clr_data(cdata1));

   msx_ram_mapper_gen #(.RB_MODE(2)) dut_rb2 (
      .clk(clk), .reset(reset), .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1), .cpu_wr(cpu_wr),
      .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .en(en),
      .ram_block_count(count), .mapper_dout(dout_rb2), .mapper_addr(maddr_rb2),
      .clr_start(1'b0), .clr_busy(busy2), .clr_done(done2), .clr_req(req2),
      .clr_ack(1'b0), .clr_addr(caddr2), .clr_data(cdata2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One I/O write; strobe held for 'hold' cycles, then low for one cycle.
   task automatic io_write(input logic [7:0] port, input logic [7:0] data, input int unsigned hold);
      @(negedge clk);
      cpu_addr = {8'h00, port};
      cpu_dout = data;
      cpu_iorq = 1'b1;
      cpu_wr   = 1'b1;
      repeat (hold) @(negedge clk);
      cpu_iorq = 1'b0;
      cpu_wr   = 1'b0;
   endtask

   // Drive a read of 'port' and leave it active for inline sampling.
   task automatic io_read_begin(input logic [7:0] port);
      @(negedge clk);
      cpu_addr = {8'h00, port};
      cpu_iorq = 1'b1;
      cpu_rd   = 1'b1;
      #1;
   endtask

   task automatic io_read_end();
      cpu_iorq = 1'b0;
      cpu_rd   = 1'b0;
   endtask

   // Runs the clear handshake on dut0 from the current negedge and tallies
   // writes seen, ordering/stability errors and done pulses.
   task automatic run_clear(input int unsigned slow_n, input int unsigned budget,
                            input int unsigned start_at, input int unsigned chg_at,
                            input bit stop_en, input logic [21:0] stop_addr,
                            output int unsigned writes, output int unsigned bad_ord,
                            output int unsigned bad_stab, output int unsigned dones,
                            output bit finished, output bit stopped);
      int unsigned cyc, tail, exp_a;
      bit          prev_wait, sent;
      logic [21:0] prev_addr;
      writes = 0; bad_ord = 0; bad_stab = 0; dones = 0;
      finished = 1'b0; stopped = 1'b0;
      cyc = 0; tail = 0; exp_a = 0; prev_wait = 1'b0; sent = 1'b0; prev_addr = '0;
      while (cyc < budget && tail < 6) begin
         if (clr_done0) dones++;
         if (prev_wait && (clr_req0 !== 1'b1 || clr_addr0 !== prev_addr)) bad_stab++;
         if (stop_en && clr_req0 && clr_addr0 == stop_addr) begin
            clr_ack = 1'b0;
            stopped = 1'b1;
            break;
         end
         clr_start = 1'b0;
         if (writes == start_at && !sent) begin
            clr_start = 1'b1;
            sent = 1'b1;
         end
         if (writes == chg_at) count = 9'd16;
         clr_ack = (writes < slow_n) ? (cyc % 3 == 2) : 1'b1;
         if (clr_req0 && clr_ack) begin
            if (clr_addr0 !== exp_a[21:0]) bad_ord++;
            exp_a++;
            writes++;
         end
         prev_wait = clr_req0 && !clr_ack;
         prev_addr = clr_addr0;
         if (dones != 0) tail++;
         @(negedge clk);
         cyc++;
      end
      finished = (tail >= 6);
      clr_ack   = 1'b0;
      clr_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cpu_iorq = 1'b0; cpu_m1 = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
      cpu_addr = 16'h4123; cpu_dout = 8'h00; en = 1'b1;
      count = 9'd16; count10 = 11'd1024; clr_start = 1'b0; clr_ack = 1'b0;
      #1;
      tot_cnt++; if (maddr0 !== 22'h000123) $display("FAIL reset_maddr: got %h, expected %h", maddr0, 22'h000123); else pass_cnt++;
      tot_cnt++; if ({clr_busy0, clr_req0, clr_done0} !== 3'b000) $display("FAIL reset_clr_flags: got %b, expected 000", {clr_busy0, clr_req0, clr_done0}); else pass_cnt++;
      tot_cnt++; if (clr_addr0 !== 22'h0) $display("FAIL reset_clr_addr: got %h, expected 0", clr_addr0); else pass_cnt++;
      tot_cnt++; if (dout0 !== 8'hFF) $display("FAIL reset_dout: got %h, expected FF", dout0); else pass_cnt++;
      // strobe already high when reset releases must not commit
      cpu_addr = 16'h00FC; cpu_dout = 8'h55; cpu_iorq = 1'b1; cpu_wr = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000;
      #1;
      tot_cnt++; if (maddr0 !== 22'h000000) $display("FAIL reset_release_no_commit: got %h, expected %h", maddr0, 22'h000000); else pass_cnt++;
   endtask

   task automatic test_basic();
      io_write(8'hFD, 8'h05, 1);
      io_read_begin(8'hFD);
      tot_cnt++; if (dout0 !== 8'hF5) $display("FAIL basic_rb0: got %h, expected F5", dout0); else pass_cnt++;
      tot_cnt++; if (dout_rb1 !== 8'h05) $display("FAIL basic_rb1: got %h, expected 05", dout_rb1); else pass_cnt++;
      tot_cnt++; if (dout_rb2 !== 8'hFF) $display("FAIL basic_rb2: got %h, expected FF", dout_rb2); else pass_cnt++;
      io_read_end();
      cpu_addr = 16'h4123;
      #1;
      tot_cnt++; if (maddr0 !== 22'h014123) $display("FAIL basic_maddr: got %h, expected %h", maddr0, 22'h014123); else pass_cnt++;
   endtask

   task automatic test_strobe();
      @(negedge clk);
      cpu_addr = 16'h00FC; cpu_dout = 8'h07; cpu_iorq = 1'b1; cpu_wr = 1'b1;
      @(negedge clk);
      cpu_dout = 8'h0A;
      repeat (4) @(negedge clk);
      cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000;
      #1;
      tot_cnt++; if (maddr0 !== 22'h01C000) $display("FAIL strobe_single_commit: got %h, expected %h", maddr0, 22'h01C000); else pass_cnt++;
      // IORQ with M1 is interrupt acknowledge, never a port access
      @(negedge clk);
      cpu_addr = 16'h00FC; cpu_m1 = 1'b1; cpu_iorq = 1'b1; cpu_wr = 1'b1; cpu_dout = 8'h03;
      repeat (2) @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      #1;
      tot_cnt++; if (dout0 !== 8'hFF) $display("FAIL inta_dout: got %h, expected FF", dout0); else pass_cnt++;
      cpu_rd = 1'b0; cpu_iorq = 1'b0; cpu_m1 = 1'b0; cpu_addr = 16'h0000;
      #1;
      tot_cnt++; if (maddr0 !== 22'h01C000) $display("FAIL inta_no_commit: got %h, expected %h", maddr0, 22'h01C000); else pass_cnt++;
   endtask

   task automatic test_readback();
      io_read_begin(8'hFC);
      tot_cnt++; if (dout0 !== 8'hF7) $display("FAIL rb0_fc: got %h, expected F7", dout0); else pass_cnt++;
      tot_cnt++; if (dout_rb1 !== 8'h07) $display("FAIL rb1_fc: got %h, expected 07", dout_rb1); else pass_cnt++;
      tot_cnt++; if (dout_rb2 !== 8'hFF) $display("FAIL rb2_fc: got %h, expected FF", dout_rb2); else pass_cnt++;
      en = 1'b0;
      #1;
      tot_cnt++; if (dout0 !== 8'hFF) $display("FAIL rb_en0: got %h, expected FF", dout0); else pass_cnt++;
      en = 1'b1;
      count = 9'd0;
      #1;
      tot_cnt++; if (dout0 !== 8'hFF) $display("FAIL rb_count0: got %h, expected FF", dout0); else pass_cnt++;
      tot_cnt++; if (dout_rb1 !== 8'hFF) $display("FAIL rb1_count0: got %h, expected FF", dout_rb1); else pass_cnt++;
      tot_cnt++; if (maddr0 !== 22'h0000FC) $display("FAIL maddr_count0: got %h, expected %h", maddr0, 22'h0000FC); else pass_cnt++;
      io_read_end();
      count = 9'd16;
   endtask

   task automatic test_back_to_back();
      io_write(8'hFC, 8'h01, 1);
      io_write(8'hFD, 8'h02, 1);
      io_write(8'hFE, 8'h03, 1);
      io_write(8'hFE, 8'h06, 1);
      @(negedge clk);
      cpu_addr = 16'h0000;
      #1;
      tot_cnt++; if (maddr0 !== 22'h004000) $display("FAIL b2b_page0: got %h, expected %h", maddr0, 22'h004000); else pass_cnt++;
      cpu_addr = 16'h4000;
      #1;
      tot_cnt++; if (maddr0 !== 22'h008000) $display("FAIL b2b_page1: got %h, expected %h", maddr0, 22'h008000); else pass_cnt++;
      cpu_addr = 16'h8000;
      #1;
      tot_cnt++; if (maddr0 !== 22'h018000) $display("FAIL b2b_page2: got %h, expected %h", maddr0, 22'h018000); else pass_cnt++;
   endtask

   task automatic test_ext();
      io_write(8'hF7, 8'h02, 1);
      io_write(8'hFE, 8'h34, 1);
      @(negedge clk);
      cpu_addr = 16'h8000;
      #1;
      tot_cnt++; if (maddr10 !== 24'h8D0000) $display("FAIL ext_maddr: got %h, expected %h", maddr10, 24'h8D0000); else pass_cnt++;
      tot_cnt++; if (maddr0 !== 22'h010000) $display("FAIL ext_ignored_seg8: got %h, expected %h", maddr0, 22'h010000); else pass_cnt++;
      io_read_begin(8'hFE);
      tot_cnt++; if (dout10 !== 8'h34) $display("FAIL ext_rb0: got %h, expected 34", dout10); else pass_cnt++;
      io_read_end();
      io_write(8'hFF, 8'h11, 1);
      @(negedge clk);
      cpu_addr = 16'hC000;
      #1;
      tot_cnt++; if (maddr10 !== 24'h844000) $display("FAIL ext_persist: got %h, expected %h", maddr10, 24'h844000); else pass_cnt++;
      count10 = 11'd256;
      cpu_addr = 16'h8000;
      #1;
      tot_cnt++; if (maddr10 !== 24'h0D0000) $display("FAIL ext_mask256: got %h, expected %h", maddr10, 24'h0D0000); else pass_cnt++;
   endtask

   task automatic test_clear();
      int unsigned writes, bad_ord, bad_stab, dones;
      bit          finished, stopped;
      // ack with no request pending does nothing
      @(negedge clk);
      clr_ack = 1'b1;
      repeat (3) @(negedge clk);
      tot_cnt++; if ({clr_busy0, clr_req0, clr_done0} !== 3'b000) $display("FAIL clr_idle_ack: got %b, expected 000", {clr_busy0, clr_req0, clr_done0}); else pass_cnt++;
      clr_ack = 1'b0;
      // count 0: done pulse only
      count = 9'd0;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      tot_cnt++; if ({clr_busy0, clr_req0, clr_done0} !== 3'b001) $display("FAIL clr_count0: got %b, expected 001", {clr_busy0, clr_req0, clr_done0}); else pass_cnt++;
      @(negedge clk);
      tot_cnt++; if (clr_done0 !== 1'b0) $display("FAIL clr_count0_pulse: got %b, expected 0", clr_done0); else pass_cnt++;
      // full clear of two blocks
      count = 9'd2;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      tot_cnt++; if ({clr_busy0, clr_req0, clr_addr0} !== {2'b11, 22'h0}) $display("FAIL clr_begin: got %b %b %h, expected 1 1 0", clr_busy0, clr_req0, clr_addr0); else pass_cnt++;
      run_clear(512, 40000, 100, 200, 1'b0, 22'h0, writes, bad_ord, bad_stab, dones, finished, stopped);
      tot_cnt++; if (!finished) $display("FAIL clr_timeout: finished %0d, expected 1", finished); else pass_cnt++;
      tot_cnt++; if (writes !== 32768) $display("FAIL clr_writes: got %0d, expected 32768", writes); else pass_cnt++;
      tot_cnt++; if (bad_ord !== 0) $display("FAIL clr_order: %0d out-of-order writes, expected 0", bad_ord); else pass_cnt++;
      tot_cnt++; if (bad_stab !== 0) $display("FAIL clr_stable: %0d unstable waits, expected 0", bad_stab); else pass_cnt++;
      tot_cnt++; if (dones !== 1) $display("FAIL clr_done_count: got %0d, expected 1", dones); else pass_cnt++;
      tot_cnt++; if ({clr_busy0, clr_req0} !== 2'b00) $display("FAIL clr_end_flags: got %b, expected 00", {clr_busy0, clr_req0}); else pass_cnt++;
      tot_cnt++; if (clr_data0 !== 8'h00) $display("FAIL clr_data: got %h, expected 00", clr_data0); else pass_cnt++;
   endtask

   task automatic test_reset_clear();
      int unsigned writes, bad_ord, bad_stab, dones;
      bit          finished, stopped;
      count = 9'd1;
      @(negedge clk);
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      run_clear(0, 2000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 22'h000100, writes, bad_ord, bad_stab, dones, finished, stopped);
      tot_cnt++; if (!stopped) $display("FAIL rst_reach_100: stopped %0d, expected 1", stopped); else pass_cnt++;
      reset = 1'b1;
      #1;
      tot_cnt++; if ({clr_busy0, clr_req0, clr_addr0} !== {2'b00, 22'h0}) $display("FAIL rst_async_abort: got %b %b %h, expected 0 0 0", clr_busy0, clr_req0, clr_addr0); else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      repeat (4) begin
         @(negedge clk);
         if (clr_done0) dones++;
      end
      tot_cnt++; if (dones !== 0 || clr_busy0 !== 1'b0) $display("FAIL rst_no_done: got done %0d busy %b, expected 0 0", dones, clr_busy0); else pass_cnt++;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      run_clear(0, 20000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 22'h0, writes, bad_ord, bad_stab, dones, finished, stopped);
      tot_cnt++; if (writes !== 16384 || bad_ord !== 0 || !finished) $display("FAIL rst_restart: got writes %0d bad %0d finished %0d, expected 16384 0 1", writes, bad_ord, finished); else pass_cnt++;
      tot_cnt++; if (dones !== 1) $display("FAIL rst_restart_done: got %0d, expected 1", dones); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strobe();
      test_readback();
      test_back_to_back();
      test_ext();
      test_clear();
      test_reset_clear();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
